// File: rtl/cond_logic_if.sv
// Decoder-to-conditional-stage bus: raw requests in, committed strobes and
// architectural flag state out.
interface cond_logic_if;
    logic        en;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [3:0]  FlagW;
    logic        PCS;
    logic        RegW;
    logic        MemW;
    logic        PCSrc;
    logic        RegWrite;
    logic        MemWrite;
    logic        CondEx;
    logic        CarryIn;
    logic [3:0]  Flags;
    logic [15:0] ExecCount;
    logic [15:0] SquashCount;

    // Decoder / controller side: drives requests, observes results.
    modport master (
        output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        input  PCSrc, RegWrite, MemWrite, CondEx, CarryIn, Flags,
        input  ExecCount, SquashCount
    );

    // Conditional-execution stage side.
    modport slave (
        input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        output PCSrc, RegWrite, MemWrite, CondEx, CarryIn, Flags,
        output ExecCount, SquashCount
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, ARM condition check,
// write-strobe gating, and saturating executed/squashed instruction counters.
module cond_logic (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic [3:0]  flags_r;
    logic [15:0] exec_cnt_r;
    logic [15:0] squash_cnt_r;
    logic        cond_ex_s;
    logic        n_s;
    logic        z_s;
    logic        c_s;
    logic        v_s;

    // Condition evaluation uses the stored flags, never this cycle's ALU flags.
    assign n_s = flags_r[3];
    assign z_s = flags_r[2];
    assign c_s = flags_r[1];
    assign v_s = flags_r[0];

    // Decode the 4-bit condition field against stored NZCV.
    always_comb begin
        cond_ex_s = 1'b1;
        case (bus.Cond)
            4'b0000: cond_ex_s = z_s;
            4'b0001: cond_ex_s = ~z_s;
            4'b0010: cond_ex_s = c_s;
            4'b0011: cond_ex_s = ~c_s;
            4'b0100: cond_ex_s = n_s;
            4'b0101: cond_ex_s = ~n_s;
            4'b0110: cond_ex_s = v_s;
            4'b0111: cond_ex_s = ~v_s;
            4'b1000: cond_ex_s = c_s & ~z_s;
            4'b1001: cond_ex_s = ~c_s | z_s;
            4'b1010: cond_ex_s = (n_s == v_s);
            4'b1011: cond_ex_s = (n_s != v_s);
            4'b1100: cond_ex_s = ~z_s & (n_s == v_s);
            4'b1101: cond_ex_s = z_s | (n_s != v_s);
            4'b1110: cond_ex_s = 1'b1;
            default: cond_ex_s = 1'b1;
        endcase
    end

    // Committed strobes are combinational so the datapath acts in the same cycle.
    always_comb begin
        bus.PCSrc    = bus.PCS  & cond_ex_s & bus.en;
        bus.RegWrite = bus.RegW & cond_ex_s & bus.en;
        bus.MemWrite = bus.MemW & cond_ex_s & bus.en;
    end

    assign bus.CondEx      = cond_ex_s;
    assign bus.CarryIn     = flags_r[1];
    assign bus.Flags       = flags_r;
    assign bus.ExecCount   = exec_cnt_r;
    assign bus.SquashCount = squash_cnt_r;

    // Flag register: per-bit load of ALU flags only for advanced, passing instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (bus.en && cond_ex_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.FlagW[i]) begin
                    flags_r[i] <= bus.ALUFlags[i];
                end else begin
                    flags_r[i] <= flags_r[i];
                end
            end
        end else begin
            flags_r <= flags_r;
        end
    end

    // Event counters: exactly one saturating counter moves per advanced cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt_r   <= 16'd0;
            squash_cnt_r <= 16'd0;
        end else if (bus.en) begin
            if (cond_ex_s) begin
                if (exec_cnt_r != 16'hFFFF) begin
                    exec_cnt_r <= exec_cnt_r + 16'd1;
                end else begin
                    exec_cnt_r <= exec_cnt_r;
                end
            end else begin
                if (squash_cnt_r != 16'hFFFF) begin
                    squash_cnt_r <= squash_cnt_r + 16'd1;
                end else begin
                    squash_cnt_r <= squash_cnt_r;
                end
            end
        end else begin
            exec_cnt_r   <= exec_cnt_r;
            squash_cnt_r <= squash_cnt_r;
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: hand-computed vectors checked with
// immediate assertions at each comparison point.
module tb_cond_logic;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    cond_logic_if bus ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] c, input logic [3:0] fw,
                         input logic [3:0] af, input logic p, input logic r, input logic m);
        bus.en       = e;
        bus.Cond     = c;
        bus.FlagW    = fw;
        bus.ALUFlags = af;
        bus.PCS      = p;
        bus.RegW     = r;
        bus.MemW     = m;
        #1;
    endtask

    task automatic chk_cond(input string tag, input logic [3:0] c, input logic exp);
        bus.Cond = c;
        #1;
        chk(tag, {15'd0, bus.CondEx}, {15'd0, exp});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_flags",   {12'd0, bus.Flags}, 16'h0000);
        chk("rst_carry",   {15'd0, bus.CarryIn}, 16'h0000);
        chk("rst_exec",    bus.ExecCount, 16'h0000);
        chk("rst_squash",  bus.SquashCount, 16'h0000);
        chk_cond("rst_eq", 4'h0, 1'b0);
        chk_cond("rst_ne", 4'h1, 1'b1);
        chk_cond("rst_al", 4'hE, 1'b1);
        chk_cond("rst_nv", 4'hF, 1'b1);

        // EQ fails on zero flags: register write squashed
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("eq_fail_condex", {15'd0, bus.CondEx}, 16'h0000);
        chk("eq_fail_regw",   {15'd0, bus.RegWrite}, 16'h0000);
        tick();
        chk("eq_fail_squash", bus.SquashCount, 16'h0001);
        chk("eq_fail_exec",   bus.ExecCount, 16'h0000);

        // CMP-like AL write of Z
        drive(1'b1, 4'hE, 4'hF, 4'h4, 1'b0, 1'b1, 1'b0);
        chk("cmp_regw",  {15'd0, bus.RegWrite}, 16'h0001);
        chk("cmp_old_flags", {12'd0, bus.Flags}, 16'h0000);
        tick();
        chk("cmp_flags", {12'd0, bus.Flags}, 16'h0004);
        chk("cmp_exec",  bus.ExecCount, 16'h0001);

        // EQ now passes, memory write committed
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("eq_pass_condex", {15'd0, bus.CondEx}, 16'h0001);
        chk("eq_pass_memw",   {15'd0, bus.MemWrite}, 16'h0001);
        tick();
        chk("eq_pass_exec", bus.ExecCount, 16'h0002);

        // Set all flags, then partial write keeping V
        drive(1'b1, 4'hE, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        chk("all_flags",  {12'd0, bus.Flags}, 16'h000F);
        chk("all_carry",  {15'd0, bus.CarryIn}, 16'h0001);
        drive(1'b1, 4'hE, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("partial_flags", {12'd0, bus.Flags}, 16'h0001);

        // Clear flags, then failed flag-setter
        drive(1'b1, 4'hE, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("clr_flags", {12'd0, bus.Flags}, 16'h0000);
        drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        chk("failset_pcsrc", {15'd0, bus.PCSrc}, 16'h0000);
        tick();
        chk("failset_flags",  {12'd0, bus.Flags}, 16'h0000);
        chk("failset_squash", bus.SquashCount, 16'h0002);
        chk("failset_exec",   bus.ExecCount, 16'h0005);

        // Flags = 1001: signed conditions
        drive(1'b1, 4'hE, 4'hF, 4'h9, 1'b0, 1'b0, 1'b0);
        tick();
        bus.en    = 1'b0;
        bus.FlagW = 4'h0;
        chk_cond("f9_ge", 4'hA, 1'b1);
        chk_cond("f9_lt", 4'hB, 1'b0);
        chk_cond("f9_gt", 4'hC, 1'b1);
        chk_cond("f9_le", 4'hD, 1'b0);

        // Flags = 1101 (N Z V set, C clear)
        drive(1'b1, 4'hE, 4'hF, 4'hD, 1'b0, 1'b0, 1'b0);
        tick();
        bus.en    = 1'b0;
        bus.FlagW = 4'h0;
        chk_cond("fd_gt", 4'hC, 1'b0);
        chk_cond("fd_le", 4'hD, 1'b1);
        chk_cond("fd_cs", 4'h2, 1'b0);
        chk_cond("fd_cc", 4'h3, 1'b1);
        chk_cond("fd_mi", 4'h4, 1'b1);
        chk_cond("fd_pl", 4'h5, 1'b0);
        chk_cond("fd_vs", 4'h6, 1'b1);
        chk_cond("fd_vc", 4'h7, 1'b0);
        chk_cond("fd_hi", 4'h8, 1'b0);
        chk_cond("fd_ls", 4'h9, 1'b1);
        chk_cond("fd_ne", 4'h1, 1'b0);

        // Back-to-back writes; carry seen in the writing cycle is the old one
        drive(1'b1, 4'hE, 4'hF, 4'h2, 1'b0, 1'b0, 1'b0);
        chk("adc_old_carry", {15'd0, bus.CarryIn}, 16'h0000);
        tick();
        chk("adc_new_carry", {15'd0, bus.CarryIn}, 16'h0001);
        drive(1'b1, 4'hE, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0);
        tick();
        chk("b2b_flags", {12'd0, bus.Flags}, 16'h000A);
        chk("b2b_exec",  bus.ExecCount, 16'h0009);

        // Reset mid-stream discards the in-flight write
        reset = 1'b1;
        drive(1'b1, 4'hE, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        chk("midrst_flags",  {12'd0, bus.Flags}, 16'h0000);
        chk("midrst_exec",   bus.ExecCount, 16'h0000);
        chk("midrst_squash", bus.SquashCount, 16'h0000);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("midrst_eq", {15'd0, bus.CondEx}, 16'h0000);

        // Saturation: 65537 AL cycles
        drive(1'b1, 4'hE, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        chk("sat_pre", bus.ExecCount, 16'hFFFE);
        tick();
        tick();
        tick();
        chk("sat_exec",   bus.ExecCount, 16'hFFFF);
        chk("sat_squash", bus.SquashCount, 16'h0000);
        tick();
        chk("sat_hold", bus.ExecCount, 16'hFFFF);

        // Stall: nothing moves, strobes low
        drive(1'b0, 4'hE, 4'hF, 4'h5, 1'b1, 1'b1, 1'b1);
        chk("stall_pcsrc", {15'd0, bus.PCSrc}, 16'h0000);
        chk("stall_regw",  {15'd0, bus.RegWrite}, 16'h0000);
        chk("stall_memw",  {15'd0, bus.MemWrite}, 16'h0000);
        chk("stall_condex", {15'd0, bus.CondEx}, 16'h0001);
        tick();
        chk("stall_flags",  {12'd0, bus.Flags}, 16'h0000);
        chk("stall_exec",   bus.ExecCount, 16'hFFFF);
        chk("stall_squash", bus.SquashCount, 16'h0000);

        // Resume with a failing condition: squash counter moves
        drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("resume_regw", {15'd0, bus.RegWrite}, 16'h0000);
        tick();
        chk("resume_squash", bus.SquashCount, 16'h0001);
        chk("resume_exec",   bus.ExecCount, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage of the SimpleARM controller, directly downstream of the main/ALU decoder. It holds the architectural NZCV flag register, evaluates each instruction's 4-bit ARM condition field against the stored flags, and gates the decoder's raw write strobes (PCS, RegW, MemW, FlagW) into the committed strobes that drive the datapath. It also supplies the stored carry to the ALU for ADC/SBC/RSC and keeps two saturating event counters for debug visibility.

## Interface
- No parameters. All widths are fixed.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  stage advance. When 0, all state holds and committed strobes are forced to 0.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V}, with bit 3 = N, bit 2 = Z, bit 1 = C, bit 0 = V.
- FlagW  in  4  per-flag write request from the decoder, same bit order as ALUFlags.
- PCS  in  1  raw PC-write request from the decoder.
- RegW  in  1  raw register-write request.
- MemW  in  1  raw memory-write request.
- PCSrc  out  1  committed PC write.
- RegWrite  out  1  committed register write.
- MemWrite  out  1  committed memory write.
- CondEx  out  1  condition-pass for the current instruction.
- CarryIn  out  1  stored C flag, used as the ALU carry input.
- Flags  out  4  stored NZCV register.
- ExecCount  out  16  number of advanced instructions whose condition passed; saturating.
- SquashCount  out  16  number of advanced instructions whose condition failed; saturating.

## Operation
- Condition evaluation is combinational from Cond and the stored Flags, not from ALUFlags:
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C & !Z. LS 1001: !C | Z.
  - GE 1010: N == V. LT 1011: N != V.
  - GT 1100: !Z & (N == V). LE 1101: Z | (N != V).
  - AL 1110: 1. 1111 is treated as AL: 1.
- Committed strobes:
  - PCSrc = PCS & CondEx & en.
  - RegWrite = RegW & CondEx & en.
  - MemWrite = MemW & CondEx & en.
- Flag register: on each rising edge with en=1 and CondEx=1, every bit i with FlagW[i]=1 loads ALUFlags[i]; bits with FlagW[i]=0 hold.
- A failed condition updates no flags, whatever FlagW says.
- en=0 updates no flags.
- Counters: on each rising edge with en=1, ExecCount increments if CondEx=1, otherwise SquashCount increments.
  - Both counters saturate at 16'hFFFF and do not wrap.
  - Exactly one counter changes per advanced cycle.
- Reset (reset=1 at a rising edge) has priority over en and all write requests:
  - Flags <= 4'b0000.
  - ExecCount <= 0.
  - SquashCount <= 0.
- Reset values of outputs, with raw inputs low:
  - Flags = 0, CarryIn = 0, ExecCount = 0, SquashCount = 0.
  - CondEx follows Cond against Flags = 0: EQ fails, NE passes, AL passes.
  - PCSrc, RegWrite and MemWrite are 0 whenever PCS, RegW, MemW or en is 0.
- Strobe outputs are not registered and are not forced low during reset. The controller holds en=0 while reset is asserted.

## Timing
- Zero-cycle latency from Cond, Flags and the raw strobes to CondEx and the committed strobes. This is a purely combinational path within the cycle.
- Flag update latency is one cycle. A flag-setting instruction in cycle t affects CondEx and CarryIn starting in cycle t+1; cycle t itself sees the old flags.
  - Consequence: ADCS in cycle t uses the old C and writes the new C at the end of cycle t.
- Back-to-back flag writes: each cycle's write lands in order, and the last write wins per bit.
- Stall (en=0): Flags and counters hold, and the committed strobes are 0. When en returns to 1, evaluation resumes with the same Flags.
- Reset mid-stream: the flag write of the instruction in the reset cycle is discarded. The next cycle evaluates against Flags = 0.
- Counters update on the same edge as the flags and are visible in the following cycle.

## Test plan
- Reset, then Cond=0000 (EQ), RegW=1, en=1 -> CondEx=0, RegWrite=0, and SquashCount=1 after the edge.
- CMP result: FlagW=1111, ALUFlags=0100, Cond=1110 -> Flags=0100 next cycle. Then Cond=0000 with MemW=1 -> MemWrite=1 and CondEx=1.
- Partial write: Flags=1111, FlagW=1110, ALUFlags=0000 -> Flags=0001 next cycle (V kept).
- Failed flag-setter: Flags=0000, Cond=0000, FlagW=1111, ALUFlags=1111 -> Flags stay 0000, and PCSrc=0 even with PCS=1.
- Signed conditions: Flags=1001 (N=1, V=1) -> GE passes, LT fails, GT passes. Flags=1101 -> GT fails, LE passes.
- Saturation and stall: 65 537 AL cycles with en=1 -> ExecCount=FFFF and holds. Then en=0 with FlagW=1111 -> Flags unchanged, all strobes 0, counters unchanged.
